// File: rtl/host_transmitter_pkg.sv
// Shared definitions for the transmit-direction DMA engine: FSM encoding,
// framing bit positions and master-bus header tags.
package host_transmitter_pkg;

  // Transmit FSM states
  typedef enum logic [3:0] {
    TX_IDLE  = 4'd0,
    REQ0     = 4'd1,
    REQ1     = 4'd2,
    REQ2     = 4'd3,
    WAIT_LEN = 4'd4,
    DATA     = 4'd5,
    DRAIN    = 4'd6,
    GAP      = 4'd7,
    ADVANCE  = 4'd8
  } tx_state_t;

  // 18-bit FIFO framing: start/end markers on master/completion words,
  // byte-valid flag on PHY words.
  localparam int START_BIT     = 17;
  localparam int END_BIT       = 16;
  localparam int PHY_VALID_BIT = 8;

  // Master-bus header tags (read issued here, write used by the receive path)
  localparam logic [7:0] TAG_RD = 8'h10;
  localparam logic [7:0] TAG_WR = 8'h90;

  // Bytes carried by one completion halfword
  localparam int HW_BYTES = 2;

  // Clamp a host-supplied frame length to what fits in a slot
  function automatic logic [15:0] clamp_len(input logic [15:0] raw,
                                            input logic [15:0] max_len);
    return (raw > max_len) ? max_len : raw;
  endfunction

endpackage

// File: rtl/host_transmitter_byte_splitter.sv
// Halfword-to-byte buffer: holds one completion halfword and hands out its
// bytes high byte first. A new halfword may only be loaded while empty.
module tx_byte_splitter
  import host_transmitter_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        pop,
  input  logic        flush,
  output logic        empty,
  output logic [7:0]  byte_out
);

  logic [1:0] count_reg;
  logic [1:0] count_next;

  genvar gi;
  generate
    for (gi = 0; gi < HW_BYTES; gi++) begin : g_lane
      logic [7:0] lane_reg;
      // Capture one byte lane of the incoming halfword; lane 0 is the high byte
      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          lane_reg <= '0;
        end else if (load) begin
          lane_reg <= load_data[8*(HW_BYTES-1-gi) +: 8];
        end
      end
    end
  endgenerate

  // Occupancy: flush wins (drops an odd trailing byte), load fills, pop drains
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = 2'd0;
    end else if (load) begin
      count_next = 2'(HW_BYTES);
    end else if (pop && (count_reg != 2'd0)) begin
      count_next = count_reg - 2'd1;
    end
  end

  // Occupancy register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign empty    = (count_reg == 2'd0);
  assign byte_out = (count_reg == 2'd2) ? g_lane[0].lane_reg : g_lane[1].lane_reg;

endmodule

// File: rtl/host_transmitter.sv
// Transmit DMA engine: reads one ring slot per frame from host memory via the
// master FIFO, serialises the completion payload into the PHY TX FIFO,
// appends an inter-frame gap and advances the consumer pointer.
module host_transmitter
  import host_transmitter_pkg::*;
#(
  parameter int         SLOT_WORDS = 32,
  parameter int         IFG_BYTES  = 12,
  parameter logic [7:0] RD_TAG     = TAG_RD
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  dma_status,
  input  logic [29:0] dma_addr_start,
  input  logic [29:0] dma_addr_end,
  input  logic [29:0] dma_addr_tail,
  output logic [29:0] dma_addr_cur,
  output logic [17:0] mst_din,
  input  logic        mst_full,
  output logic        mst_wr_en,
  input  logic [17:0] cpl_dout,
  input  logic        cpl_empty,
  output logic        cpl_rd_en,
  output logic [17:0] phy_din,
  input  logic        phy_full,
  output logic        phy_wr_en,
  output logic [15:0] tx_frames
);

  localparam logic [29:0] SLOT_DW      = 30'(SLOT_WORDS / 2);
  localparam logic [15:0] MAXLEN       = 16'(2 * (SLOT_WORDS - 1));
  localparam logic [7:0]  SLOT_WORDS_B = 8'(SLOT_WORDS);
  localparam logic [15:0] IFG_LAST     = (IFG_BYTES > 0) ? 16'(IFG_BYTES - 1) : 16'd0;
  // Where a finished frame goes next; a zero gap skips straight to the pointer update
  localparam tx_state_t   POST_FRAME   = (IFG_BYTES > 0) ? GAP : ADVANCE;

  tx_state_t   state_reg, state_next;
  logic [29:0] cur_reg, cur_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;
  logic        end_seen_reg, end_seen_next;   // last popped completion word carried END
  logic        trunc_reg, trunc_next;         // completion ended before len bytes
  logic [15:0] frames_reg, frames_next;

  logic        split_load, split_pop, split_flush, split_empty;
  logic [7:0]  split_byte;
  logic [15:0] hdr_len;

  // Bits of the status word other than TX enable, and the receive-path tag, are not used here
  logic unused_ok;
  assign unused_ok = &{1'b0, dma_status[7:2], dma_status[0], TAG_WR};

  assign hdr_len = clamp_len(cpl_dout[15:0], MAXLEN);

  tx_byte_splitter u_splitter (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .load      (split_load),
    .load_data (cpl_dout[15:0]),
    .pop       (split_pop),
    .flush     (split_flush),
    .empty     (split_empty),
    .byte_out  (split_byte)
  );

  // Next-state, datapath updates and FIFO strobes
  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    end_seen_next = end_seen_reg;
    trunc_next    = trunc_reg;
    frames_next   = frames_reg;
    mst_wr_en     = 1'b0;
    mst_din       = '0;
    cpl_rd_en     = 1'b0;
    phy_wr_en     = 1'b0;
    phy_din       = '0;
    split_load    = 1'b0;
    split_pop     = 1'b0;
    split_flush   = 1'b0;

    case (state_reg)
      TX_IDLE: begin
        byte_cnt_next = '0;
        gap_cnt_next  = '0;
        end_seen_next = 1'b0;
        trunc_next    = 1'b0;
        if (cur_reg == '0) begin
          cur_next = dma_addr_start;
        end else if (dma_status[1] && (cur_reg != dma_addr_tail)) begin
          state_next = REQ0;
        end
      end

      REQ0: begin
        if (!mst_full) begin
          mst_wr_en  = 1'b1;
          mst_din    = {2'b10, RD_TAG, SLOT_WORDS_B};
          state_next = REQ1;
        end
      end

      REQ1: begin
        if (!mst_full) begin
          mst_wr_en  = 1'b1;
          mst_din    = {2'b00, cur_reg[29:14]};
          state_next = REQ2;
        end
      end

      REQ2: begin
        if (!mst_full) begin
          mst_wr_en  = 1'b1;
          mst_din    = {2'b01, cur_reg[13:0], 2'b00};
          state_next = WAIT_LEN;
        end
      end

      WAIT_LEN: begin
        // Skip stray words until the header carrying the byte length
        if (!cpl_empty) begin
          cpl_rd_en     = 1'b1;
          end_seen_next = cpl_dout[END_BIT];
          if (cpl_dout[START_BIT]) begin
            len_next = hdr_len;
            if (hdr_len == '0) begin
              state_next = cpl_dout[END_BIT] ? ADVANCE : DRAIN;
            end else begin
              state_next = DATA;
            end
          end
        end
      end

      DATA: begin
        if (split_empty) begin
          if (end_seen_reg) begin
            // Completion finished short of len: frame is abandoned but still gapped
            trunc_next = 1'b1;
            state_next = POST_FRAME;
          end else if (!cpl_empty) begin
            cpl_rd_en     = 1'b1;
            split_load    = 1'b1;
            end_seen_next = cpl_dout[END_BIT];
          end
        end else if (!phy_full) begin
          phy_wr_en                = 1'b1;
          phy_din[PHY_VALID_BIT]   = 1'b1;
          phy_din[7:0]             = split_byte;
          split_pop                = 1'b1;
          byte_cnt_next            = byte_cnt_reg + 16'd1;
          if ((byte_cnt_reg + 16'd1) == len_reg) begin
            split_flush = 1'b1;
            state_next  = end_seen_reg ? POST_FRAME : DRAIN;
          end
        end
      end

      DRAIN: begin
        if (!cpl_empty) begin
          cpl_rd_en = 1'b1;
          if (cpl_dout[END_BIT]) begin
            state_next = (len_reg == '0) ? ADVANCE : POST_FRAME;
          end
        end
      end

      GAP: begin
        if (!phy_full) begin
          phy_wr_en    = 1'b1;
          gap_cnt_next = gap_cnt_reg + 16'd1;
          if (gap_cnt_reg == IFG_LAST) begin
            state_next = ADVANCE;
          end
        end
      end

      ADVANCE: begin
        cur_next = (cur_reg == dma_addr_end) ? dma_addr_start : cur_reg + SLOT_DW;
        if ((len_reg != '0) && !trunc_reg) begin
          frames_next = frames_reg + 16'd1;
        end
        state_next = TX_IDLE;
      end

      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= TX_IDLE;
      cur_reg      <= '0;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      end_seen_reg <= 1'b0;
      trunc_reg    <= 1'b0;
      frames_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      end_seen_reg <= end_seen_next;
      trunc_reg    <= trunc_next;
      frames_reg   <= frames_next;
    end
  end

  assign dma_addr_cur = cur_reg;
  assign tx_frames    = frames_reg;

endmodule

// File: doc/host_transmitter.md
Name: host_transmitter

Overview:
- Transmit-direction DMA engine paired with the existing receive path.
- Fetches fixed-size frame slots from a host ring buffer by issuing read requests into the Master FIFO, and accepts the returned completion halfwords from a completion FIFO.
- Serialises each frame's bytes into the PHY TX FIFO with the same 18-bit framing as the PHY RX FIFO, then inserts an inter-frame gap and advances the ring pointer.

Parameters:
SLOT_WORDS, 32, halfwords per ring slot (halfword 0 = frame byte length, rest = payload); even, 4..256
IFG_BYTES, 12, idle bytes written to the PHY FIFO after each frame
RD_TAG, 8'h10, header byte identifying a read request on the master bus

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
dma_status  in  8  bit1 = TX enable
dma_addr_start  in  30  [31:2] ring base (dword address)
dma_addr_end  in  30  [31:2] address of last slot
dma_addr_tail  in  30  [31:2] host producer pointer
dma_addr_cur  out  30  [31:2] consumer pointer (registered)
mst_din  out  18  master FIFO word: [17]=start, [16]=end, [15:0]=payload
mst_full  in  1  master FIFO full
mst_wr_en  out  1  master FIFO write strobe
cpl_dout  in  18  completion FIFO word (first-word-fall-through); same start/end framing
cpl_empty  in  1  completion FIFO empty
cpl_rd_en  out  1  pop; combinational; never high while cpl_empty
phy_din  out  18  [8]=frame byte valid, [7:0]=byte, [17:9]=0
phy_full  in  1  PHY TX FIFO full
phy_wr_en  out  1  PHY FIFO write strobe
tx_frames  out  16  count of frames sent; wraps

Behaviour:
- Reset values: dma_addr_cur=0, mst_wr_en=0, phy_wr_en=0, mst_din=0, phy_din=0, tx_frames=0, FSM in TX_IDLE, byte buffer empty.
- Reset mid-frame abandons the frame. The bench resets the completion FIFO alongside.
- Slot size in dwords: SLOT_DW = SLOT_WORDS/2.
- Maximum frame length: MAXLEN = 2*(SLOT_WORDS-1).
- TX_IDLE:
  - If dma_addr_cur==0, load dma_addr_start.
  - Advance to REQ0 when dma_status[1]=1, dma_addr_cur!=dma_addr_tail and the pointer is nonzero.
- REQ0 / REQ1 / REQ2: each state writes one word and advances only on a cycle with mst_full=0; otherwise it holds with mst_wr_en=0.
  - REQ0: {2'b10, RD_TAG, SLOT_WORDS[7:0]}
  - REQ1: {2'b00, addr[31:16]}
  - REQ2: {2'b01, addr[15:2], 2'b00}
- WAIT_LEN:
  - Pop words until one has [17]=1. Discard any non-start words.
  - From the start word, latch len = min(cpl_dout[15:0], MAXLEN).
  - If len=0, go to DRAIN. Otherwise go to DATA.
- DATA:
  - Each payload halfword is popped only when the internal byte buffer is empty.
  - Bytes are emitted high byte [15:8] first, then [7:0].
  - One byte is written per cycle with phy_wr_en=1, phy_din={9'h001, byte}, and only while phy_full=0. No byte is lost or duplicated across a stall.
  - Emitting the len-th byte goes to DRAIN, discarding the odd trailing low byte if any.
- DRAIN:
  - Pop remaining words up to and including [16]=1. If the last popped word already had [16]=1, skip DRAIN.
  - Then go to GAP, or to ADVANCE if len=0.
- GAP: write IFG_BYTES words of phy_din=18'h0, phy_wr_en=1, each stalling on phy_full.
- ADVANCE (one cycle):
  - dma_addr_cur <= (dma_addr_cur==dma_addr_end) ? dma_addr_start : dma_addr_cur+SLOT_DW.
  - tx_frames += 1 if len != 0.
  - Return to TX_IDLE.
- A completion end word ([16]=1) arriving before len bytes have been emitted:
  - Stop emitting bytes.
  - Still apply the gap.
  - Do not increment tx_frames.
- Clearing dma_status[1] mid-frame does not truncate the frame. The FSM parks in TX_IDLE after ADVANCE.
- Changes to dma_addr_tail are sampled only in TX_IDLE.
- Throughput: at most one master write per cycle and one PHY byte per cycle; request-to-first-byte latency is 3 cycles plus completion latency.

Decomposition:
- Shared package holds:
  - FSM state encodings (TX_IDLE, REQ0, REQ1, REQ2, WAIT_LEN, DATA, DRAIN, GAP, ADVANCE).
  - Framing bit positions (START=17, END=16, PHY_VALID=8).
  - RD_TAG, and the write tag 8'h90 already used by the receive path.
- One natural sub-module, tx_byte_splitter: a 16-to-8 halfword-to-byte buffer with pop/stall handshake.

Test Plan:
- Reset, start=0x100, end=0x130, tail=0x110, enable:
  - Master FIFO gets 3 words: 0x2_1020, 0x0_0000, 0x1_0400.
  - Completion len=5, bytes AA BB CC DD EE → PHY gets 1AA,1BB,1CC,1DD,1EE then 12 words of 0x000.
  - dma_addr_cur=0x110, tx_frames=1.
- Wrap: cur=end=0x130, tail=0x100 → after one frame, cur=0x100.
- phy_full toggled every other cycle during a 62-byte frame:
  - Exactly 62 valid bytes, in order, none duplicated.
  - Gap still exactly 12 bytes.
- Length 0xFFFF → clamped to 62 bytes; length 0 → no PHY writes, cur advances, tx_frames unchanged.
- mst_full held for 10 cycles at REQ1 → no mst_wr_en during the stall, request words intact and in order afterwards.
- sys_rst asserted mid-DATA → all outputs return to reset values next cycle; enable again → restarts from dma_addr_start.
